// File: rtl/sram_controller_if.sv
// MEM-stage request bus plus external 16-bit asynchronous SRAM pins.
// The controller uses the slave modport; the MEM stage/SRAM side uses master.
interface sram_controller_if #(
    parameter int ADDR_W = 17
);
    logic [31:0]       addr;
    logic [31:0]       wr_data;
    logic              MEM_R_en;
    logic              MEM_W_en;
    logic [31:0]       rd_data;
    logic              ready;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [15:0]       SRAM_DQ_out;
    logic              SRAM_DQ_oe;
    logic [15:0]       SRAM_DQ_in;
    logic              SRAM_WE_N;
    logic              SRAM_OE_N;

    modport slave (
        input  addr, wr_data, MEM_R_en, MEM_W_en, SRAM_DQ_in,
        output rd_data, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
        output SRAM_WE_N, SRAM_OE_N
    );

    modport master (
        output addr, wr_data, MEM_R_en, MEM_W_en, SRAM_DQ_in,
        input  rd_data, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
        input  SRAM_WE_N, SRAM_OE_N
    );
endinterface

// File: rtl/sram_controller.sv
// 32-bit word load/store over a 16-bit async SRAM, upper halfword first.
// Define SRAM_READ_BUFFER_EN to add a one-entry read buffer.
module sram_controller #(
    parameter int ADDR_W       = 17,
    parameter int PHASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus
);
    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-2:0] waddr;
    logic [31:0]       wdata;
    logic              is_wr;
    logic [15:0]       rd_hi;

    logic              req;
    logic              last;
    logic              hit;
    logic [31:0]       hit_data;
    logic [ADDR_W-2:0] req_waddr;
    logic              unused_addr;

    assign req         = bus.MEM_R_en | bus.MEM_W_en;
    assign req_waddr   = bus.addr[ADDR_W:2];
    assign last        = (cnt == CW'(PHASE_CYCLES - 1));
    assign unused_addr = ^{bus.addr[31:ADDR_W+1], bus.addr[1:0]};
    assign bus.ready   = (state == IDLE && !req) || state == DONE;

`ifdef SRAM_READ_BUFFER_EN
    logic              buf_valid;
    logic [ADDR_W-2:0] buf_addr;
    logic [31:0]       buf_data;

    assign hit      = buf_valid && !bus.MEM_W_en && buf_addr == req_waddr;
    assign hit_data = buf_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (state == IDLE && bus.MEM_W_en && buf_addr == req_waddr) begin
            buf_valid <= 1'b0;
        end else if (state == LO && last && !is_wr) begin
            buf_valid <= 1'b1;
            buf_addr  <= waddr;
            buf_data  <= {rd_hi, bus.SRAM_DQ_in};
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            waddr           <= '0;
            wdata           <= '0;
            is_wr           <= 1'b0;
            rd_hi           <= '0;
            bus.rd_data     <= '0;
            bus.SRAM_ADDR   <= '0;
            bus.SRAM_DQ_out <= '0;
            bus.SRAM_DQ_oe  <= 1'b0;
            bus.SRAM_WE_N   <= 1'b1;
            bus.SRAM_OE_N   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        waddr <= req_waddr;
                        wdata <= bus.wr_data;
                        is_wr <= bus.MEM_W_en;
                        cnt   <= '0;
                        if (hit) begin
                            state       <= DONE;
                            bus.rd_data <= hit_data;
                        end else begin
                            state           <= HI;
                            bus.SRAM_ADDR   <= {req_waddr, 1'b0};
                            bus.SRAM_DQ_out <= bus.wr_data[31:16];
                            bus.SRAM_DQ_oe  <= bus.MEM_W_en;
                            bus.SRAM_WE_N   <= ~bus.MEM_W_en;
                            bus.SRAM_OE_N   <= bus.MEM_W_en;
                        end
                    end
                end
                HI: begin
                    if (last) begin
                        state           <= LO;
                        cnt             <= '0;
                        bus.SRAM_ADDR   <= {waddr, 1'b1};
                        bus.SRAM_DQ_out <= wdata[15:0];
                        if (!is_wr) rd_hi <= bus.SRAM_DQ_in;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LO: begin
                    if (last) begin
                        state          <= DONE;
                        cnt            <= '0;
                        bus.SRAM_DQ_oe <= 1'b0;
                        bus.SRAM_WE_N  <= 1'b1;
                        bus.SRAM_OE_N  <= 1'b1;
                        if (!is_wr) bus.rd_data <= {rd_hi, bus.SRAM_DQ_in};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage initiator that turns the pipeline's 32-bit word load/store requests into sequences on an external 16-bit asynchronous SRAM. Each word is two halfword accesses, upper half first, so memory is big-endian with the byte at the lowest address as MSB. It sits between the MEM stage and the SRAM pins. `ready` low freezes the pipeline until the access completes.

## Interface
- `ADDR_W`, 17: halfword-address width on the SRAM side. Word address is `addr[ADDR_W:2]`.
- `PHASE_CYCLES`, 2: cycles each halfword phase holds address and control. Minimum 1.
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `addr` in 32: byte address from MEM stage. Bits `[1:0]` are ignored. Bits above `ADDR_W` are ignored.
- `wr_data` in 32: store data.
- `MEM_R_en` in 1: load request.
- `MEM_W_en` in 1: store request.
- `rd_data` out 32: load result. Valid when `ready`=1 in DONE.
- `ready` out 1: high when idle with no request, or in DONE. Low otherwise (pipeline freeze).
- `SRAM_ADDR` out ADDR_W: halfword address.
- `SRAM_DQ_out` out 16: write data.
- `SRAM_DQ_oe` out 1: drive DQ. High only during write phases.
- `SRAM_DQ_in` in 16: read data.
- `SRAM_WE_N` out 1: write enable, active low.
- `SRAM_OE_N` out 1: output enable, active low.

## Operation
- FSM states and transitions:
  - IDLE → HI: on `MEM_W_en | MEM_R_en`.
  - HI → LO: after `PHASE_CYCLES` cycles.
  - LO → DONE: after `PHASE_CYCLES` cycles.
  - DONE → IDLE: unconditional.
- Phase counter: counts 0..`PHASE_CYCLES`-1 within HI/LO and clears on every state change.
- Request latch: `addr`, `wr_data` and op are latched on leaving IDLE. Input changes during an access are ignored.
- `MEM_W_en` and `MEM_R_en` both high: treated as a write. `rd_data` is unchanged.
- HI phase: `SRAM_ADDR={waddr,1'b0}`, carries bits `[31:16]`.
- LO phase: `SRAM_ADDR={waddr,1'b1}`, carries bits `[15:0]`.
- Read phases: `SRAM_OE_N`=0, `SRAM_WE_N`=1, `SRAM_DQ_oe`=0. `SRAM_DQ_in` is sampled on the last cycle of the phase into the corresponding half of `rd_data`.
- Write phases: `SRAM_WE_N`=0 and `SRAM_DQ_oe`=1 for every cycle of the phase, with `SRAM_DQ_out` the phase's halfword. `SRAM_OE_N`=1.
- IDLE/DONE: `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ_oe`=0. `SRAM_ADDR` holds its last value.
- `ready` is combinational: `(state==IDLE & ~MEM_R_en & ~MEM_W_en) | state==DONE`.
- The next request is accepted only from IDLE. A request present in the DONE cycle is ignored there and started from IDLE on the following cycle.
- `rd_data` holds until the next completed read.

## Timing
- Reset values:
  - state IDLE, counter 0
  - `rd_data`=0, `SRAM_ADDR`=0, `SRAM_DQ_out`=0
  - `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ_oe`=0
  - `ready`=1 if no request is present
- Latency: request presented in IDLE at cycle 0 → `ready`=1 at cycle 2·`PHASE_CYCLES`+1. With default 2, that is cycle 5, i.e. 5 frozen cycles.
- Back-to-back requests: 2·`PHASE_CYCLES`+2 cycles per access.
- Reset mid-access: IDLE at the next edge and `SRAM_WE_N` high. The partial write is abandoned (the SRAM half may already be written). `rd_data` is cleared and the buffer below is invalidated.
- Word address wraps modulo 2^(ADDR_W-1).

## Configuration
- `SRAM_READ_BUFFER_EN` defined:
  - One-entry buffer holds the last completed read's word address and data, with a valid bit.
  - A read hitting a valid entry in IDLE goes directly to DONE: `ready`=1 one cycle after the request, no SRAM activity, `rd_data` loaded from the buffer.
  - A write to the buffered word invalidates the entry. Reset invalidates it.
- Not defined: every read performs both SRAM phases; no buffer registers exist.

## Test plan
- Write then read, `PHASE_CYCLES`=2:
  - Write `addr`=0x10 with 0xDEADBEEF → `SRAM_ADDR`=8 with DQ 0xDEAD (2 cycles, `WE_N` low), then 9 with 0xBEEF; `ready` at cycle 5.
  - Read 0x10 → `rd_data`=0xDEADBEEF at cycle 5.
- Both enables high at 0x20 with 0x12345678 → write occurs and `rd_data` is unchanged; a subsequent read returns 0x12345678.
- `addr`=0x13 and 0x10 access the same word. `addr` bit `ADDR_W+1` set aliases to bit-clear.
- `rst` asserted in the LO write phase → next cycle IDLE, `WE_N`=1, `DQ_oe`=0, `rd_data`=0.
- Two reads 0x40 then 0x44 back-to-back → each request frozen 5 cycles, 6 cycles apart; `OE_N` high in DONE/IDLE.
- With `SRAM_READ_BUFFER_EN`:
  - Read 0x40 twice → second completes in 1 cycle with no `OE_N` pulse.
  - Write 0x40 then read 0x40 → full 5-cycle access.
